// File: rtl/frame_buffer_ctrl.sv
// frame_buffer_ctrl: writes a valid/ready greyscale pixel stream into the back
// bank of an external dual-port frame RAM and maps the display read address
// onto the front bank, expanding the read byte to 24-bit grey.
// Configuration macro: FB_DOUBLE_BUFFER_EN. When defined, two banks are used
// and they swap on the VSYNC falling edge once a full frame has been written.
// When undefined, a single bank is used, bank bits are tied to 0, VSYNC is
// ignored and FRAME_DONE pulses right after the last write of a frame.
module frame_buffer_ctrl #(
    parameter int IMG_X  = 640,
    parameter int IMG_Y  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              CLK_PX,
    input  logic              RST_n,
    input  logic              S_VALID,
    output logic              S_READY,
    input  logic [7:0]        S_DATA,
    input  logic              S_SOF,
    input  logic              VSYNC,
    input  logic [ADDR_W-1:0] PX_ADDR,
    output logic [23:0]       PX,
    output logic [ADDR_W:0]   RD_ADDR,
    input  logic [7:0]        RD_DATA,
    output logic              WR_EN,
    output logic [ADDR_W:0]   WR_ADDR,
    output logic [7:0]        WR_DATA,
    output logic              DISP_BANK,
    output logic              FRAME_DONE,
    output logic              ERR
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_X * IMG_Y - 1);
    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_PEND  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic [ADDR_W-1:0] w_next_cnt;
    logic [ADDR_W-1:0] w_wr_idx;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_wr_en;
    logic              r_err;
    logic              r_frame_done;
    logic              w_ready;
    logic              w_wr;
    logic              w_err_set;
    logic              w_done;
    logic              w_vs_fall;
    logic              w_disp_bank;

    // FSM state register
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge CLK_PX or negedge RST_n) begin
        if (!RST_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state, handshake and write-command decode
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_wr_cnt;
        w_wr_idx     = r_wr_cnt;
        w_ready      = 1'b1;
        w_wr         = 1'b0;
        w_err_set    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Pixels outside a frame are accepted and dropped until SOF.
                if (S_VALID && S_SOF) begin
                    w_wr         = 1'b1;
                    w_wr_idx     = '0;
                    w_next_cnt   = CNT_ONE;
                    w_next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (S_VALID) begin
                    w_wr = 1'b1;
                    if (S_SOF) begin
                        // Restart: the partial frame is overwritten.
                        w_wr_idx   = '0;
                        w_next_cnt = CNT_ONE;
                        w_err_set  = 1'b1;
                    end else if (r_wr_cnt == LAST_PIX) begin
`ifdef FB_DOUBLE_BUFFER_EN
                        w_next_state = ST_PEND;
`else
                        w_next_state = ST_IDLE;
                        w_done       = 1'b1;
`endif
                    end else begin
                        w_next_cnt = r_wr_cnt + CNT_ONE;
                    end
                end
            end
            ST_PEND: begin
                // Full frame waiting for vertical blank; stall the source.
                w_ready = 1'b0;
                if (w_vs_fall) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Registered write port, frame counter, done pulse and sticky error
    always_ff @(posedge CLK_PX or negedge RST_n) begin
        if (!RST_n) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_cnt     <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_wr_en      <= w_wr;
            r_wr_cnt     <= w_next_cnt;
            r_frame_done <= w_done;
            if (w_wr) begin
                r_wr_addr <= w_wr_idx;
                r_wr_data <= S_DATA;
            end
            if (w_err_set) r_err <= 1'b1;
        end
    end

`ifdef FB_DOUBLE_BUFFER_EN
    logic r_vs_q;
    logic r_disp_bank;
    logic r_wr_bank;

    assign w_vs_fall   = r_vs_q & ~VSYNC;
    assign w_disp_bank = r_disp_bank;

    // VSYNC edge detect, displayed bank toggle and write bank capture
    always_ff @(posedge CLK_PX or negedge RST_n) begin
        if (!RST_n) begin
            r_vs_q      <= 1'b1;
            r_disp_bank <= 1'b0;
            r_wr_bank   <= 1'b0;
        end else begin
            r_vs_q <= VSYNC;
            if (w_done) r_disp_bank <= ~r_disp_bank;
            if (w_wr)   r_wr_bank   <= ~r_disp_bank;
        end
    end

    assign WR_ADDR = {r_wr_bank, r_wr_addr};
`else
    logic w_vsync_unused;

    assign w_vsync_unused = VSYNC;
    assign w_vs_fall      = 1'b0;
    assign w_disp_bank    = 1'b0;
    assign WR_ADDR        = {1'b0, r_wr_addr};
`endif

    assign S_READY    = w_ready;
    assign WR_EN      = r_wr_en;
    assign WR_DATA    = r_wr_data;
    assign FRAME_DONE = r_frame_done;
    assign ERR        = r_err;
    assign DISP_BANK  = w_disp_bank;
    assign RD_ADDR    = {w_disp_bank, PX_ADDR};
    assign PX         = {RD_DATA, RD_DATA, RD_DATA};

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Testbench for frame_buffer_ctrl (IMG_X=4, IMG_Y=2, ADDR_W=3). Follows the
// build's FB_DOUBLE_BUFFER_EN setting. A frame-level model predicts outputs
// every cycle; directed scenarios add literal expectations.
module tb_frame_buffer_ctrl;

`ifdef FB_DOUBLE_BUFFER_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif
    localparam int N       = 8;  // pixels per frame
    localparam int BANK_SZ = 8;  // 2**ADDR_W

    logic        CLK_PX = 1'b0;
    logic        RST_n;
    logic        S_VALID;
    logic        S_READY;
    logic [7:0]  S_DATA;
    logic        S_SOF;
    logic        VSYNC;
    logic [2:0]  PX_ADDR;
    logic [23:0] PX;
    logic [3:0]  RD_ADDR;
    logic [7:0]  RD_DATA;
    logic        WR_EN;
    logic [3:0]  WR_ADDR;
    logic [7:0]  WR_DATA;
    logic        DISP_BANK;
    logic        FRAME_DONE;
    logic        ERR;

    frame_buffer_ctrl #(.IMG_X(4), .IMG_Y(2), .ADDR_W(3)) dut (
        .CLK_PX(CLK_PX), .RST_n(RST_n), .S_VALID(S_VALID), .S_READY(S_READY),
        .S_DATA(S_DATA), .S_SOF(S_SOF), .VSYNC(VSYNC), .PX_ADDR(PX_ADDR),
        .PX(PX), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .WR_EN(WR_EN),
        .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .DISP_BANK(DISP_BANK),
        .FRAME_DONE(FRAME_DONE), .ERR(ERR)
    );

    always #5 CLK_PX = ~CLK_PX;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: m_idx is the next pixel index of the frame being
    // received (-1 = waiting for SOF), m_full = a finished frame awaits swap.
    int m_idx     = -1;
    bit m_full    = 1'b0;
    bit m_bank    = 1'b0;
    bit m_err     = 1'b0;
    bit m_vs      = 1'b1;
    bit e_wr_en   = 1'b0;
    bit e_done    = 1'b0;
    int e_wr_addr = 0;
    int e_wr_data = 0;

    // Model update on each clock edge from the pre-edge inputs
    always @(posedge CLK_PX or negedge RST_n) begin
        if (!RST_n) begin
            m_idx = -1; m_full = 1'b0; m_bank = 1'b0; m_err = 1'b0; m_vs = 1'b1;
            e_wr_en = 1'b0; e_done = 1'b0; e_wr_addr = 0; e_wr_data = 0;
        end else begin
            e_wr_en = 1'b0;
            e_done  = 1'b0;
            if (S_VALID && !m_full) begin
                if (S_SOF) begin
                    if (m_idx >= 0) m_err = 1'b1;
                    m_idx = 0;
                end
                if (m_idx >= 0) begin
                    e_wr_en   = 1'b1;
                    e_wr_addr = ((DBL && !m_bank) ? BANK_SZ : 0) + m_idx;
                    e_wr_data = int'(S_DATA);
                    if (m_idx == N - 1) begin
                        m_idx = -1;
                        if (DBL) m_full = 1'b1;
                        else     e_done = 1'b1;
                    end else begin
                        m_idx++;
                    end
                end
            end else if (DBL && m_full && m_vs && !VSYNC) begin
                m_full = 1'b0;
                m_bank = !m_bank;
                e_done = 1'b1;
            end
            m_vs = VSYNC;
        end
    end

    // Per-cycle comparison against the model plus write/done logging
    int q_addr[$];
    int q_data[$];
    int done_cnt = 0;
    always @(negedge CLK_PX) begin
        check("s_ready", 32'(S_READY), 32'(!m_full));
        check("wr_en", 32'(WR_EN), 32'(e_wr_en));
        if (e_wr_en) begin
            check("wr_addr", 32'(WR_ADDR), e_wr_addr);
            check("wr_data", 32'(WR_DATA), e_wr_data);
        end
        check("frame_done", 32'(FRAME_DONE), 32'(e_done));
        check("disp_bank", 32'(DISP_BANK), 32'(m_bank));
        check("err", 32'(ERR), 32'(m_err));
        check("rd_addr", 32'(RD_ADDR), (m_bank ? BANK_SZ : 0) + int'(PX_ADDR));
        check("px", 32'(PX), int'(RD_DATA) * 32'h010101);
        if (WR_EN === 1'b1) begin
            q_addr.push_back(int'(WR_ADDR));
            q_data.push_back(int'(WR_DATA));
        end
        if (FRAME_DONE === 1'b1) done_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK_PX);
        #2;
    endtask

    task automatic send(input logic [7:0] d, input logic sof);
        S_VALID = 1'b1;
        S_DATA  = d;
        S_SOF   = sof;
        @(posedge CLK_PX);
        #2;
        S_VALID = 1'b0;
        S_SOF   = 1'b0;
    endtask

    task automatic vsync_fall();
        VSYNC = 1'b0;
        idle(2);
        VSYNC = 1'b1;
        idle(1);
    endtask

    initial begin
        RST_n = 1'b1; S_VALID = 1'b0; S_DATA = 8'h00; S_SOF = 1'b0;
        VSYNC = 1'b1; PX_ADDR = 3'd5; RD_DATA = 8'h00;
        #1 RST_n = 1'b0;
        idle(2);

        // Reset values
        check("rst s_ready", 32'(S_READY), 1);
        check("rst wr_en", 32'(WR_EN), 0);
        check("rst wr_addr", 32'(WR_ADDR), 0);
        check("rst wr_data", 32'(WR_DATA), 0);
        check("rst disp_bank", 32'(DISP_BANK), 0);
        check("rst frame_done", 32'(FRAME_DONE), 0);
        check("rst err", 32'(ERR), 0);
        check("rst rd_addr", 32'(RD_ADDR), 5);
        RST_n = 1'b1;
        idle(1);

        // Full frame 0x10..0x17, SOF on the first pixel
        q_addr.delete(); q_data.delete();
        for (int i = 0; i < N; i++) send(8'(8'h10 + i), i == 0);
        idle(2);
        check("frame1 writes", q_addr.size(), 8);
        if (q_addr.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("frame1 addr", q_addr[i], (DBL ? 8 : 0) + i);
                check("frame1 data", q_data[i], 32'h10 + i);
            end
        end
        check("frame1 s_ready", 32'(S_READY), DBL ? 0 : 1);
        check("frame1 disp_bank", 32'(DISP_BANK), 0);
        check("frame1 done_cnt", done_cnt, DBL ? 0 : 1);

        // VSYNC falling edge swaps banks (double-buffer build only)
        vsync_fall();
        check("swap disp_bank", 32'(DISP_BANK), DBL ? 1 : 0);
        check("swap done_cnt", done_cnt, 1);
        check("swap s_ready", 32'(S_READY), 1);
        PX_ADDR = 3'd2;
        RD_DATA = 8'h12;
        #1;
        check("read rd_addr", 32'(RD_ADDR), DBL ? 32'b1010 : 32'b0010);
        check("read px", 32'(PX), 32'h121212);
        idle(1);

        // Idle transfers without SOF are dropped
        q_addr.delete(); q_data.delete();
        for (int i = 0; i < 3; i++) send(8'(8'h20 + i), 1'b0);
        idle(2);
        check("idle writes", q_addr.size(), 0);
        check("idle err", 32'(ERR), 0);

        // SOF on the 5th pixel restarts the frame and sets ERR
        q_addr.delete(); q_data.delete();
        for (int i = 0; i < 4; i++) send(8'(8'h30 + i), i == 0);
        for (int i = 0; i < N; i++) send(8'(8'h40 + i), i == 0);
        idle(2);
        check("restart writes", q_addr.size(), 12);
        if (q_addr.size() == 12) begin
            check("restart addr3", q_addr[3], 3);
            check("restart addr4", q_addr[4], 0);
            check("restart data4", q_data[4], 32'h40);
            check("restart addr11", q_addr[11], 7);
        end
        check("restart err", 32'(ERR), 1);
        check("restart s_ready", 32'(S_READY), DBL ? 0 : 1);
        vsync_fall();
        check("restart swap err", 32'(ERR), 1);
        check("restart swap bank", 32'(DISP_BANK), 0);
        check("restart done_cnt", done_cnt, 2);

        // VSYNC falling edge mid-frame is ignored, then reset while in PEND
        q_addr.delete(); q_data.delete();
        for (int i = 0; i < 3; i++) send(8'(8'h50 + i), i == 0);
        vsync_fall();
        check("midframe bank", 32'(DISP_BANK), 0);
        check("midframe done_cnt", done_cnt, 2);
        for (int i = 3; i < N; i++) send(8'(8'h50 + i), 1'b0);
        check("midframe writes", q_addr.size(), 7);
        if (q_addr.size() == 7) begin
            check("midframe addr0", q_addr[0], DBL ? 8 : 0);
            check("midframe addr6", q_addr[6], (DBL ? 8 : 0) + 6);
        end
        check("last wr_en", 32'(WR_EN), 1);
        check("last wr_addr", 32'(WR_ADDR), (DBL ? 8 : 0) + 7);
        check("pend s_ready", 32'(S_READY), DBL ? 0 : 1);
        RST_n = 1'b0;
        #1;
        check("arst wr_en", 32'(WR_EN), 0);
        check("arst wr_addr", 32'(WR_ADDR), 0);
        check("arst s_ready", 32'(S_READY), 1);
        check("arst err", 32'(ERR), 0);
        check("arst disp_bank", 32'(DISP_BANK), 0);
        check("arst frame_done", 32'(FRAME_DONE), 0);
        idle(2);
        RST_n = 1'b1;
        idle(2);
        check("post rst s_ready", 32'(S_READY), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_buffer_ctrl.md
# frame_buffer_ctrl

Double-buffered frame-buffer manager that sits directly upstream of the HDMI controller. It accepts an 8-bit greyscale pixel stream through a valid/ready handshake and writes it into the back bank of an external dual-port RAM. It maps the controller's `PX_ADDR` onto the front bank and returns the read data as a 24-bit `PX`. Bank swap happens only at the start of the vertical sync pulse, so a frame is never displayed half-written.

## Interface

Parameters
- `IMG_X`, default 640: pixels per line.
- `IMG_Y`, default 480: lines per frame.
- `ADDR_W`, default 19: per-bank address width. Requires 2^ADDR_W >= IMG_X*IMG_Y.

Ports
- `CLK_PX`  in  1: pixel clock; all logic on its rising edge.
- `RST_n`  in  1: reset, asynchronous, active-low.
- `S_VALID`  in  1: input pixel valid.
- `S_READY`  out  1: block can accept a pixel.
- `S_DATA`  in  8: greyscale pixel.
- `S_SOF`  in  1: marks the first pixel of a frame; qualified by a transfer.
- `VSYNC`  in  1: active-low vertical sync from the HDMI controller.
- `PX_ADDR`  in  ADDR_W: display read address from the HDMI controller.
- `PX`  out  24: `{RD_DATA, RD_DATA, RD_DATA}`.
- `RD_ADDR`  out  ADDR_W+1: `{disp_bank, PX_ADDR}` to the RAM read port.
- `RD_DATA`  in  8: RAM read data, one-cycle read latency.
- `WR_EN`  out  1: RAM write strobe.
- `WR_ADDR`  out  ADDR_W+1: `{~disp_bank, wr_cnt}`.
- `WR_DATA`  out  8: RAM write data.
- `DISP_BANK`  out  1: currently displayed bank.
- `FRAME_DONE`  out  1: one-cycle pulse on each bank swap.
- `ERR`  out  1: sticky; set when `S_SOF` arrives mid-frame.

## Operation
- A transfer occurs when `S_VALID && S_READY`. `S_READY` is 1 in IDLE and WRITE, and 0 in PEND.
- FSM states: IDLE, WRITE, PEND. Reset state is IDLE.
  - IDLE: transfers without `S_SOF` are accepted and discarded, with no write. A transfer with `S_SOF` writes the pixel to address 0, sets `wr_cnt` to 1 and moves to WRITE.
  - WRITE: each transfer writes to `wr_cnt`, then increments it. A transfer at `wr_cnt == IMG_X*IMG_Y-1` writes the last pixel and moves to PEND.
  - WRITE with `S_SOF`: the pixel is written to address 0, `wr_cnt` becomes 1, `ERR` is set, and the state stays WRITE. The partial frame is overwritten.
  - PEND: no transfers. On the VSYNC falling edge (`vs_q == 1 && VSYNC == 0`), `disp_bank` toggles, `FRAME_DONE` pulses, and the state returns to IDLE.
- A VSYNC falling edge in IDLE or WRITE has no effect.
- `wr_cnt` is ADDR_W bits and never exceeds IMG_X*IMG_Y-1. It has no modular wrap; it is cleared only by SOF or reset.
- The read path is combinational address mapping only. `disp_bank` changes only at the VSYNC edge, which falls inside vertical blank.
- `PX_ADDR` outside 0..IMG_X*IMG_Y-1 is passed through unchecked.

## Timing
- Reset values:
  - `S_READY` = 1
  - `WR_EN` = 0, `WR_ADDR` = 0, `WR_DATA` = 0
  - `DISP_BANK` = 0
  - `FRAME_DONE` = 0
  - `ERR` = 0
  - `vs_q` = 1
  - `RD_ADDR` = `{0, PX_ADDR}`
- Write latency: `WR_EN`, `WR_ADDR` and `WR_DATA` are registered. They appear one cycle after the transfer edge and hold for exactly one cycle.
- `FRAME_DONE` and the `DISP_BANK` toggle are registered in the cycle after the VSYNC falling edge is sampled.
- `S_READY` returns to 1 in that same cycle.
- The last-pixel transfer and the PEND entry happen on the same edge. `S_READY` is 0 in the following cycle.
- Reset mid-frame: the FSM goes to IDLE, `disp_bank` goes to 0, and any in-flight write is dropped (`WR_EN` = 0).
- Read: `PX` follows `RD_DATA` combinationally. End-to-end latency from `PX_ADDR` to `PX` equals the RAM latency, which is one cycle.

## Configuration
- `FB_DOUBLE_BUFFER_EN` defined: behaviour exactly as above.
- `FB_DOUBLE_BUFFER_EN` undefined: single bank.
  - The MSB of both `WR_ADDR` and `RD_ADDR` is tied to 0, and `DISP_BANK` is tied to 0.
  - PEND is removed. The last-pixel transfer goes directly to IDLE, and `FRAME_DONE` pulses one cycle later.
  - VSYNC is ignored.

## Test plan
All scenarios use IMG_X=4, IMG_Y=2, ADDR_W=3 unless stated.
- Reset, then 8 transfers with SOF on the first, data 0x10..0x17:
  - `WR_ADDR` = 8..15 with `WR_DATA` 0x10..0x17.
  - `S_READY` = 0 after the 8th transfer.
  - `DISP_BANK` stays 0.
- Continue the previous scenario and drive a VSYNC falling edge:
  - One cycle later, `FRAME_DONE` = 1 for one cycle, `DISP_BANK` = 1, `S_READY` = 1.
  - With `PX_ADDR` = 2, `RD_ADDR` = 0b1010.
  - With `RD_DATA` = 0x12, `PX` = 0x121212.
- In IDLE, 3 transfers without SOF: no `WR_EN` pulses, `ERR` stays 0.
- SOF on the 5th pixel of a frame:
  - `WR_ADDR` low bits return to 0 and `ERR` = 1.
  - 8 more pixels are needed to reach PEND.
  - `ERR` stays 1 through the later swap.
- VSYNC falling edge while in WRITE (after 3 pixels): `DISP_BANK` and `FRAME_DONE` are unchanged, and the writes continue.
- Assert `RST_n` low while in PEND: all outputs take their reset values immediately, and after release `S_READY` = 1. Also rerun with `FB_DOUBLE_BUFFER_EN` undefined: `FRAME_DONE` pulses one cycle after the 8th write with no VSYNC needed, and `WR_ADDR` MSB = 0.
